// File: rtl/vga_pkg.sv
// Shared encodings and default widths for the VGA/CPU video RAM arbiter.
package vga_pkg;

  localparam int VRAM_ADDR_WIDTH = 13;
  localparam int VRAM_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_ADDR = 3'd1,
    ST_RD_DATA = 3'd2,
    ST_WR      = 3'd3,
    ST_ACK     = 3'd4
  } state_t;

  typedef enum logic {
    OWN_VID = 1'b0,
    OWN_CPU = 1'b1
  } owner_t;

endpackage

// File: rtl/vga_sat_counter.sv
// Saturating up-counter with synchronous clear; clear wins over increment.
module vga_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clear,
  output logic [WIDTH-1:0] o_count
);

  logic [WIDTH-1:0] r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_inc && (r_count != {WIDTH{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign o_count = r_count;

endmodule

// File: rtl/vga_vram_arbiter.sv
// Single-port VRAM arbiter: video reads have fixed priority, CPU accesses fill idle slots.
// Optional CPU starvation guard enabled by defining VGA_VRAM_ARB_STARVE_GUARD_EN.
module vga_vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_WIDTH   = VRAM_ADDR_WIDTH,
  parameter int DATA_WIDTH   = VRAM_DATA_WIDTH,
  parameter int MAX_CPU_WAIT = 8
) (
  input  logic                  i_clock,
  input  logic                  i_reset,
  input  logic                  i_vid_req,
  input  logic [ADDR_WIDTH-1:0] i_vid_addr,
  output logic                  o_vid_ack,
  output logic [DATA_WIDTH-1:0] o_vid_data,
  input  logic                  i_cpu_req,
  input  logic                  i_cpu_write,
  input  logic [ADDR_WIDTH-1:0] i_cpu_addr,
  input  logic [DATA_WIDTH-1:0] i_cpu_wdata,
  output logic                  o_cpu_ack,
  output logic [DATA_WIDTH-1:0] o_cpu_rdata,
  output logic [ADDR_WIDTH-1:0] o_ram_addr,
  output logic [DATA_WIDTH-1:0] o_ram_wdata,
  output logic                  o_ram_we,
  input  logic [DATA_WIDTH-1:0] i_ram_rdata,
  input  logic                  i_stall_clear,
  output logic [15:0]           o_cpu_stall_count
);

  state_t                r_state;
  owner_t                r_owner;
  logic [ADDR_WIDTH-1:0] r_ram_addr;
  logic [DATA_WIDTH-1:0] r_ram_wdata;
  logic                  r_ram_we;
  logic                  r_vid_ack;
  logic                  r_cpu_ack;
  logic [DATA_WIDTH-1:0] r_vid_data;
  logic [DATA_WIDTH-1:0] r_cpu_rdata;

  logic w_cpu_force;
  logic w_vid_grant;
  logic w_cpu_grant;
  logic w_stall_inc;

`ifdef VGA_VRAM_ARB_STARVE_GUARD_EN
  localparam int WAIT_W = $clog2(MAX_CPU_WAIT + 1);
  logic [WAIT_W-1:0] r_wait_cnt;

  assign w_cpu_force = i_cpu_req && (r_wait_cnt == WAIT_W'(MAX_CPU_WAIT));

  // Counts only IDLE arbitrations the CPU lost to video.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_IDLE) begin
      if (w_cpu_grant) begin
        r_wait_cnt <= '0;
      end else if (w_vid_grant && i_cpu_req) begin
        r_wait_cnt <= r_wait_cnt + 1'b1;
      end
    end
  end
`else
  assign w_cpu_force = 1'b0;
`endif

  assign w_vid_grant = i_vid_req && !w_cpu_force;
  assign w_cpu_grant = i_cpu_req && !w_vid_grant;

  // The grant cycle itself counts as a wait: ownership only takes effect after it.
  assign w_stall_inc = i_cpu_req && ((r_state == ST_IDLE) || (r_owner == OWN_VID));

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_VID;
      r_ram_addr  <= '0;
      r_ram_wdata <= '0;
      r_ram_we    <= 1'b0;
      r_vid_ack   <= 1'b0;
      r_cpu_ack   <= 1'b0;
      r_vid_data  <= '0;
      r_cpu_rdata <= '0;
    end else begin
      r_vid_ack <= 1'b0;
      r_cpu_ack <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_vid_grant) begin
            r_owner    <= OWN_VID;
            r_ram_addr <= i_vid_addr;
            r_ram_we   <= 1'b0;
            r_state    <= ST_RD_ADDR;
          end else if (w_cpu_grant) begin
            r_owner     <= OWN_CPU;
            r_ram_addr  <= i_cpu_addr;
            r_ram_wdata <= i_cpu_wdata;
            r_ram_we    <= i_cpu_write;
            r_state     <= i_cpu_write ? ST_WR : ST_RD_ADDR;
          end
        end
        ST_RD_ADDR: r_state <= ST_RD_DATA;
        ST_RD_DATA: begin
          if (r_owner == OWN_VID) begin
            r_vid_data <= i_ram_rdata;
            r_vid_ack  <= 1'b1;
          end else begin
            r_cpu_rdata <= i_ram_rdata;
            r_cpu_ack   <= 1'b1;
          end
          r_state <= ST_ACK;
        end
        ST_WR: begin
          r_ram_we  <= 1'b0;
          r_cpu_ack <= 1'b1;
          r_state   <= ST_ACK;
        end
        ST_ACK:  r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  vga_sat_counter #(
    .WIDTH(16)
  ) u_stall_cnt (
    .i_clk   (i_clock),
    .i_rst   (i_reset),
    .i_inc   (w_stall_inc),
    .i_clear (i_stall_clear),
    .o_count (o_cpu_stall_count)
  );

  assign o_vid_ack   = r_vid_ack;
  assign o_vid_data  = r_vid_data;
  assign o_cpu_ack   = r_cpu_ack;
  assign o_cpu_rdata = r_cpu_rdata;
  assign o_ram_addr  = r_ram_addr;
  assign o_ram_wdata = r_ram_wdata;
  assign o_ram_we    = r_ram_we;

endmodule
